// File: rtl/mspu_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations,
// immediate formats and the decoded-control bundle.
package mspu_pkg;

    localparam int XLEN       = 32;
    localparam int REDIR_KILL = 2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        imm_type_t  imm_type;
        alu_op_t    alu_op;
        logic       alu_src;
        logic       reg_we;
        logic       mem_re;
        logic       mem_we;
        logic [2:0] mem_size;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // funct3 -> ALU op; alt selects SUB/SRA
    function automatic alu_op_t f3_alu(input logic [2:0] f3,
                                       input logic alt);
        alu_op_t op;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instruction_decode_imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate
// fields of an RV32I word; R-type and NOPs yield zero.
module instruction_decode_imm_gen
    import mspu_pkg::*;
(
    input  logic [31:7] insn,
    input  imm_type_t   imm_type,
    output logic [31:0] imm
);

    // pure field shuffle selected by format
    always_comb begin
        imm = '0;
        unique case (imm_type)
            IMM_I: imm = {{20{insn[31]}}, insn[31:20]};
            IMM_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
            IMM_B: imm = {{19{insn[31]}}, insn[31], insn[7],
                          insn[30:25], insn[11:8], 1'b0};
            IMM_U: imm = {insn[31:12], 12'b0};
            IMM_J: imm = {{11{insn[31]}}, insn[31], insn[19:12],
                          insn[20], insn[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: aligns fetch PC with imem data, decodes,
// and squashes wrong-path slots after a redirect.
module instruction_decode
    import mspu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REDIR_KILL = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_insn,
    input  logic            redirect,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_insn,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_imm,
    output logic [3:0]      id_alu_op,
    output logic            id_alu_src,
    output logic            id_reg_we,
    output logic            id_mem_re,
    output logic            id_mem_we,
    output logic [2:0]      id_mem_size,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_illegal
);

    localparam int KW = $clog2(REDIR_KILL) + 1;
    localparam logic [KW-1:0] KILL_LOAD = KW'(REDIR_KILL - 1);

    logic [XLEN-1:0] pc_q;
    logic            align_vld;
    logic [KW-1:0]   kill_cnt;
    ctrl_t           c;
    logic [31:0]     imm;
    logic            live;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1f;
    logic [4:0] rs2f;
    logic [4:0] rdf;

    assign opc  = if_insn[6:0];
    assign f3   = if_insn[14:12];
    assign f7   = if_insn[31:25];
    assign rs1f = if_insn[19:15];
    assign rs2f = if_insn[24:20];
    assign rdf  = if_insn[11:7];

    assign live = align_vld && (kill_cnt == '0) && !redirect;

    // align register and wrong-path kill counter
    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            pc_q      <= '0;
            align_vld <= 1'b0;
            kill_cnt  <= '0;
        end else begin
            pc_q      <= if_pc;
            align_vld <= 1'b1;
            if (redirect)
                kill_cnt <= KILL_LOAD;
            else if (kill_cnt != '0)
                kill_cnt <= kill_cnt - 1'b1;
        end
    end

    // opcode/funct decoder for the aligned slot
    always_comb begin
        c          = '0;
        c.alu_op   = ALU_ADD;
        c.imm_type = IMM_NONE;
        unique case (1'b1)
            (opc == OP_LUI), (opc == OP_AUIPC): begin
                c.rd       = rdf;
                c.imm_type = IMM_U;
                c.alu_src  = 1'b1;
                c.reg_we   = 1'b1;
            end
            (opc == OP_JAL): begin
                c.rd       = rdf;
                c.imm_type = IMM_J;
                c.alu_src  = 1'b1;
                c.reg_we   = 1'b1;
                c.jump     = 1'b1;
            end
            (opc == OP_JALR): begin
                if (f3 == 3'b000) begin
                    c.rs1      = rs1f;
                    c.rd       = rdf;
                    c.imm_type = IMM_I;
                    c.alu_src  = 1'b1;
                    c.reg_we   = 1'b1;
                    c.jump     = 1'b1;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            (opc == OP_BRANCH): begin
                if (f3[2:1] != 2'b01) begin
                    c.rs1      = rs1f;
                    c.rs2      = rs2f;
                    c.imm_type = IMM_B;
                    c.branch   = 1'b1;
                    c.alu_op   = !f3[2] ? ALU_SUB :
                                 (f3[1] ? ALU_SLTU : ALU_SLT);
                end else begin
                    c.illegal = 1'b1;
                end
            end
            (opc == OP_LOAD): begin
                if (f3[1:0] != 2'b11 && f3 != 3'b110) begin
                    c.rs1      = rs1f;
                    c.rd       = rdf;
                    c.imm_type = IMM_I;
                    c.alu_src  = 1'b1;
                    c.reg_we   = 1'b1;
                    c.mem_re   = 1'b1;
                    c.mem_size = f3;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            (opc == OP_STORE): begin
                if (!f3[2] && f3[1:0] != 2'b11) begin
                    c.rs1      = rs1f;
                    c.rs2      = rs2f;
                    c.imm_type = IMM_S;
                    c.alu_src  = 1'b1;
                    c.mem_we   = 1'b1;
                    c.mem_size = f3;
                end else begin
                    c.illegal = 1'b1;
                end
            end
            (opc == OP_IMM): begin
                if ((f3 == 3'b001 && f7 != 7'b0) ||
                    (f3 == 3'b101 && f7 != 7'b0 &&
                     f7 != 7'b0100000)) begin
                    c.illegal = 1'b1;
                end else begin
                    c.rs1      = rs1f;
                    c.rd       = rdf;
                    c.imm_type = IMM_I;
                    c.alu_src  = 1'b1;
                    c.reg_we   = 1'b1;
                    c.alu_op   = f3_alu(f3, f3 == 3'b101 && f7[5]);
                end
            end
            (opc == OP_REG): begin
                if (f7 == 7'b0 || (f7 == 7'b0100000 &&
                    (f3 == 3'b000 || f3 == 3'b101))) begin
                    c.rs1    = rs1f;
                    c.rs2    = rs2f;
                    c.rd     = rdf;
                    c.reg_we = 1'b1;
                    c.alu_op = f3_alu(f3, f7[5]);
                end else begin
                    c.illegal = 1'b1;
                end
            end
            (opc == OP_FENCE), (opc == OP_SYSTEM): begin
                c.illegal = 1'b0;
            end
            default: c.illegal = 1'b1;
        endcase
        if (c.rd == 5'd0 || c.illegal)
            c.reg_we = 1'b0;
    end

    instruction_decode_imm_gen u_imm_gen (
        .insn     (if_insn[31:7]),
        .imm_type (c.imm_type),
        .imm      (imm)
    );

    // ID/EX register; killed slots keep data but drop side effects
    always_ff @(posedge clk) begin
        if (!reset || !run) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_insn     <= '0;
            id_rs1      <= '0;
            id_rs2      <= '0;
            id_rd       <= '0;
            id_imm      <= '0;
            id_alu_op   <= '0;
            id_alu_src  <= 1'b0;
            id_reg_we   <= 1'b0;
            id_mem_re   <= 1'b0;
            id_mem_we   <= 1'b0;
            id_mem_size <= '0;
            id_branch   <= 1'b0;
            id_jump     <= 1'b0;
            id_illegal  <= 1'b0;
        end else begin
            id_valid    <= live;
            id_pc       <= pc_q;
            id_insn     <= if_insn;
            id_rs1      <= c.rs1;
            id_rs2      <= c.rs2;
            id_rd       <= c.rd;
            id_imm      <= XLEN'(imm);
            id_alu_op   <= c.alu_op;
            id_alu_src  <= c.alu_src;
            id_reg_we   <= c.reg_we && live;
            id_mem_re   <= c.mem_re && live;
            id_mem_we   <= c.mem_we && live;
            id_mem_size <= c.mem_size;
            id_branch   <= c.branch && live;
            id_jump     <= c.jump && live;
            id_illegal  <= c.illegal;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: drives aligned
// fetch pc / imem data by hand and checks the ID/EX register.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        redirect;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_insn;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_we;
    logic        id_mem_re;
    logic        id_mem_we;
    logic [2:0]  id_mem_size;
    logic        id_branch;
    logic        id_jump;
    logic        id_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .redirect    (redirect),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_insn     (id_insn),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_imm      (id_imm),
        .id_alu_op   (id_alu_op),
        .id_alu_src  (id_alu_src),
        .id_reg_we   (id_reg_we),
        .id_mem_re   (id_mem_re),
        .id_mem_we   (id_mem_we),
        .id_mem_size (id_mem_size),
        .id_branch   (id_branch),
        .id_jump     (id_jump),
        .id_illegal  (id_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present one cycle of fetch outputs, then sample after the edge
    task automatic drive(input logic [31:0] pc, input logic [31:0] insn,
                         input logic rdr);
        if_pc    = pc;
        if_insn  = insn;
        redirect = rdr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        run      = 1'b1;
        if_pc    = '0;
        if_insn  = '0;
        redirect = 1'b0;
        drive(32'h0, 32'h00500093, 1'b0);
        drive(32'h0, 32'h00500093, 1'b0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_insn", id_insn, 32'd0);
        chk("rst_imm", id_imm, 32'd0);
        chk("rst_rd", {27'b0, id_rd}, 32'd0);

        // scenario 1: addi x1,x0,5
        reset = 1'b1;
        drive(32'h80000000, 32'h0, 1'b0);
        chk("s1_lat_valid", {31'b0, id_valid}, 32'd0);
        drive(32'h80000004, 32'h00500093, 1'b0);
        chk("s1_valid", {31'b0, id_valid}, 32'd1);
        chk("s1_pc", id_pc, 32'h80000000);
        chk("s1_rd", {27'b0, id_rd}, 32'd1);
        chk("s1_rs1", {27'b0, id_rs1}, 32'd0);
        chk("s1_imm", id_imm, 32'd5);
        chk("s1_alu", {28'b0, id_alu_op}, 32'd0);
        chk("s1_src", {31'b0, id_alu_src}, 32'd1);
        chk("s1_we", {31'b0, id_reg_we}, 32'd1);

        // scenario 2: lui x2,0x12345
        drive(32'h80000008, 32'h12345137, 1'b0);
        chk("s2_pc", id_pc, 32'h80000004);
        chk("s2_imm", id_imm, 32'h12345000);
        chk("s2_rd", {27'b0, id_rd}, 32'd2);
        chk("s2_rs1", {27'b0, id_rs1}, 32'd0);
        chk("s2_we", {31'b0, id_reg_we}, 32'd1);
        chk("s2_src", {31'b0, id_alu_src}, 32'd1);

        // scenario 3: beq x0,x0,-4
        drive(32'h8000000C, 32'hFE000EE3, 1'b0);
        chk("s3_br", {31'b0, id_branch}, 32'd1);
        chk("s3_imm", id_imm, 32'hFFFFFFFC);
        chk("s3_we", {31'b0, id_reg_we}, 32'd0);
        chk("s3_rs", {22'b0, id_rs1, id_rs2}, 32'd0);
        chk("s3_alu", {28'b0, id_alu_op}, 32'd1);

        // sw x5,8(x2)
        drive(32'h80000010, 32'h00512423, 1'b0);
        chk("sw_we", {31'b0, id_mem_we}, 32'd1);
        chk("sw_regs", {22'b0, id_rs1, id_rs2}, {22'b0, 5'd2, 5'd5});
        chk("sw_imm", id_imm, 32'd8);
        chk("sw_size", {29'b0, id_mem_size}, 32'd2);
        chk("sw_rd", {27'b0, id_rd}, 32'd0);

        // scenario 4: single redirect, target 0x80000100
        drive(32'h80000014, 32'h00100113, 1'b1);
        chk("r1_t1_valid", {31'b0, id_valid}, 32'd0);
        chk("r1_t1_pc", id_pc, 32'h80000010);
        chk("r1_t1_rd", {27'b0, id_rd}, 32'd2);
        chk("r1_t1_we", {31'b0, id_reg_we}, 32'd0);
        drive(32'h80000100, 32'h00200193, 1'b0);
        chk("r1_t2_valid", {31'b0, id_valid}, 32'd0);
        chk("r1_t2_we", {31'b0, id_reg_we}, 32'd0);
        drive(32'h80000104, 32'hFFF00193, 1'b0);
        chk("r1_t3_valid", {31'b0, id_valid}, 32'd1);
        chk("r1_t3_pc", id_pc, 32'h80000100);
        chk("r1_t3_imm", id_imm, 32'hFFFFFFFF);
        chk("r1_t3_we", {31'b0, id_reg_we}, 32'd1);

        // back-to-back redirects; newest target 0x80000300
        drive(32'h80000108, 32'h00000013, 1'b1);
        chk("r2_a_valid", {31'b0, id_valid}, 32'd0);
        drive(32'h80000200, 32'h00000013, 1'b1);
        chk("r2_b_valid", {31'b0, id_valid}, 32'd0);
        drive(32'h80000300, 32'h00000013, 1'b0);
        chk("r2_c_valid", {31'b0, id_valid}, 32'd0);
        drive(32'h80000304, 32'h008000EF, 1'b0);
        chk("r2_d_valid", {31'b0, id_valid}, 32'd1);
        chk("r2_d_pc", id_pc, 32'h80000300);
        chk("jal_jump", {31'b0, id_jump}, 32'd1);
        chk("jal_imm", id_imm, 32'd8);
        chk("jal_we", {31'b0, id_reg_we}, 32'd1);

        // scenario 5: illegal word and addi x0
        drive(32'h80000308, 32'hFFFFFFFF, 1'b0);
        chk("ill_flag", {31'b0, id_illegal}, 32'd1);
        chk("ill_valid", {31'b0, id_valid}, 32'd1);
        chk("ill_en", {27'b0, id_reg_we, id_mem_re, id_mem_we,
                       id_branch, id_jump}, 32'd0);
        drive(32'h8000030C, 32'h00000013, 1'b0);
        chk("nop_we", {31'b0, id_reg_we}, 32'd0);
        chk("nop_ill", {31'b0, id_illegal}, 32'd0);
        drive(32'h80000310, 32'h00500090, 1'b0);
        chk("lowbits_ill", {31'b0, id_illegal}, 32'd1);
        chk("lowbits_we", {31'b0, id_reg_we}, 32'd0);

        // run low behaves as reset
        run = 1'b0;
        drive(32'h80000314, 32'h00500093, 1'b0);
        chk("run0_valid", {31'b0, id_valid}, 32'd0);
        chk("run0_pc", id_pc, 32'd0);
        run = 1'b1;
        drive(32'h80000000, 32'h0, 1'b0);
        chk("run1_lat", {31'b0, id_valid}, 32'd0);
        drive(32'h80000004, 32'h00500093, 1'b0);
        chk("run1_valid", {31'b0, id_valid}, 32'd1);
        chk("run1_pc", id_pc, 32'h80000000);

        // scenario 6: reset mid-stream
        drive(32'h80000008, 32'h12345137, 1'b0);
        chk("mid_pre", {31'b0, id_valid}, 32'd1);
        reset = 1'b0;
        drive(32'h8000000C, 32'hFE000EE3, 1'b0);
        chk("mid_valid", {31'b0, id_valid}, 32'd0);
        chk("mid_insn", id_insn, 32'd0);
        chk("mid_imm", id_imm, 32'd0);
        reset = 1'b1;
        drive(32'h80000000, 32'h0, 1'b0);
        chk("mid_lat", {31'b0, id_valid}, 32'd0);
        drive(32'h80000004, 32'h00500093, 1'b0);
        chk("mid_valid2", {31'b0, id_valid}, 32'd1);
        chk("mid_pc2", id_pc, 32'h80000000);

        // reset during a pending kill, with redirect held
        drive(32'h80000008, 32'h0, 1'b1);
        chk("pk_kill", {31'b0, id_valid}, 32'd0);
        reset = 1'b0;
        drive(32'h80000200, 32'h00000013, 1'b1);
        chk("pk_valid", {31'b0, id_valid}, 32'd0);
        chk("pk_pc", id_pc, 32'd0);
        reset = 1'b1;
        drive(32'h80000000, 32'h0, 1'b0);
        chk("pk_lat", {31'b0, id_valid}, 32'd0);
        drive(32'h80000004, 32'h00500093, 1'b0);
        chk("pk_valid2", {31'b0, id_valid}, 32'd1);
        chk("pk_pc2", id_pc, 32'h80000000);
        chk("pk_we2", {31'b0, id_reg_we}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
